// File: rtl/draw_board.sv
// Battleship board renderer: maps pixels to a 10x10 cell index, colours cells by matrix code, draws the grid.
// Optional `define CURSOR_HIGHLIGHT_EN adds input mouse_pos and a yellow outline on the selected cell.
module draw_board #(
  parameter int unsigned BOARD_X     = 64,
  parameter int unsigned BOARD_Y     = 64,
  parameter int unsigned CELL_LOG2   = 5,
  parameter logic [11:0] COLOR_WATER = 12'h05A,
  parameter logic [11:0] COLOR_SHIP  = 12'h888,
  parameter logic [11:0] COLOR_HIT   = 12'hF00,
  parameter logic [11:0] COLOR_MISS  = 12'hFFF,
  parameter logic [11:0] COLOR_GRID  = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [1:0]  ship_code,
`ifdef CURSOR_HIGHLIGHT_EN
  input  logic [7:0]  mouse_pos,
`endif
  output logic [6:0]  ship_xy,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int unsigned BOARD_W = 10 << CELL_LOG2;
  localparam int unsigned TIM_W   = 26;

  logic             w_in_board;
  logic [10:0]      w_off_x, w_off_y;
  logic [3:0]       w_col, w_row;
  logic [6:0]       w_xy;
  logic             w_grid;
  logic [TIM_W-1:0] w_tim_in;
  logic [11:0]      w_rgb;

  logic [TIM_W-1:0] r_tim1, r_tim2, r_tim3;
  logic [11:0]      r_rgb1, r_rgb2, r_rgb3;
  logic             r_in1, r_in2, r_grid1, r_grid2;
  logic [6:0]       r_xy;
`ifdef CURSOR_HIGHLIGHT_EN
  logic             w_cur;
  logic             r_cur1, r_cur2;
`endif

  // Timing bundle: {hcount, hsync, hblnk, vcount, vsync, vblnk}
  assign w_tim_in = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};

  assign w_in_board = (hcount_in >= 11'(BOARD_X)) && (hcount_in < 11'(BOARD_X + BOARD_W)) &&
                      (vcount_in >= 11'(BOARD_Y)) && (vcount_in < 11'(BOARD_Y + BOARD_W));

  // Offsets are forced to zero off-board so the subtraction never wraps
  assign w_off_x = w_in_board ? hcount_in - 11'(BOARD_X) : '0;
  assign w_off_y = w_in_board ? vcount_in - 11'(BOARD_Y) : '0;
  assign w_col   = 4'(w_off_x >> CELL_LOG2);
  assign w_row   = 4'(w_off_y >> CELL_LOG2);
  assign w_xy    = 7'({w_row, 3'b000}) + 7'({w_row, 1'b0}) + 7'(w_col);

  assign w_grid = w_in_board &&
                  ((w_off_x[CELL_LOG2-1:0] == '0) || (w_off_y[CELL_LOG2-1:0] == '0) ||
                   (w_off_x == 11'(BOARD_W - 1)) || (w_off_y == 11'(BOARD_W - 1)));

`ifdef CURSOR_HIGHLIGHT_EN
  assign w_cur = w_in_board && (w_row == mouse_pos[7:4]) && (w_col == mouse_pos[3:0]);
`endif

  // Stage 3 colour select; blanking wins over everything
  always_comb begin
    w_rgb = r_rgb2;
    if (r_tim2[13] || r_tim2[0])
      w_rgb = 12'h000;
    else if (!r_in2)
      w_rgb = r_rgb2;
`ifdef CURSOR_HIGHLIGHT_EN
    else if (r_cur2 && r_grid2)
      w_rgb = 12'hFF0;
`endif
    else if (r_grid2)
      w_rgb = COLOR_GRID;
    else begin
      case (ship_code)
        2'b00:   w_rgb = COLOR_WATER;
        2'b01:   w_rgb = COLOR_SHIP;
        2'b10:   w_rgb = COLOR_HIT;
        default: w_rgb = COLOR_MISS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tim1  <= '0;
      r_tim2  <= '0;
      r_tim3  <= '0;
      r_rgb1  <= '0;
      r_rgb2  <= '0;
      r_rgb3  <= '0;
      r_in1   <= 1'b0;
      r_in2   <= 1'b0;
      r_grid1 <= 1'b0;
      r_grid2 <= 1'b0;
      r_xy    <= '0;
`ifdef CURSOR_HIGHLIGHT_EN
      r_cur1  <= 1'b0;
      r_cur2  <= 1'b0;
`endif
    end else begin
      r_tim1  <= w_tim_in;
      r_tim2  <= r_tim1;
      r_tim3  <= r_tim2;
      r_rgb1  <= rgb_in;
      r_rgb2  <= r_rgb1;
      r_rgb3  <= w_rgb;
      r_in1   <= w_in_board;
      r_in2   <= r_in1;
      r_grid1 <= w_grid;
      r_grid2 <= r_grid1;
      r_xy    <= w_in_board ? w_xy : 7'd0;
`ifdef CURSOR_HIGHLIGHT_EN
      r_cur1  <= w_cur;
      r_cur2  <= r_cur1;
`endif
    end
  end

  assign ship_xy = r_xy;
  assign {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} = r_tim3;
  assign rgb_out = r_rgb3;

endmodule

// File: tb/tb_draw_board.sv
// Scoreboard bench for draw_board: stimulus queues expected ship_xy / pixel records, a monitor pops and compares.
module tb_draw_board;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [1:0]  ship_code;
  logic [6:0]  ship_xy;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
`ifdef CURSOR_HIGHLIGHT_EN
  logic [7:0]  mouse_pos = 8'h23;
`endif

  typedef struct { int due; logic [6:0] xy; } xy_t;
  typedef struct { int due; logic [11:0] rgb; logic [25:0] tim; } px_t;

  xy_t qx[$];
  px_t qp[$];
  xy_t mx;
  px_t mp;
  int  edge_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  logic [1:0] mem [100];

  always #5 clk = ~clk;

  draw_board dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .ship_code(ship_code),
`ifdef CURSOR_HIGHLIGHT_EN
    .mouse_pos(mouse_pos),
`endif
    .ship_xy(ship_xy),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Ship-position matrix: registered lookup one clock after ship_xy
  always @(posedge clk) ship_code <= mem[ship_xy];
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare every record whose due edge has just passed
  always @(negedge clk) begin
    while (qx.size() > 0 && qx[0].due <= edge_cnt) begin
      mx = qx.pop_front();
      checks++;
      if (ship_xy !== mx.xy) begin
        errors++;
        $display("FAIL ship_xy edge=%0d got=%0d exp=%0d", mx.due, ship_xy, mx.xy);
      end
    end
    while (qp.size() > 0 && qp[0].due <= edge_cnt) begin
      mp = qp.pop_front();
      checks += 2;
      if (rgb_out !== mp.rgb) begin
        errors++;
        $display("FAIL rgb_out edge=%0d got=%h exp=%h", mp.due, rgb_out, mp.rgb);
      end
      if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== mp.tim) begin
        errors++;
        $display("FAIL timing edge=%0d got=%h exp=%h", mp.due,
                 {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, mp.tim);
      end
    end
  end

  // Present one pixel for the next edge and queue its expected outputs
  task automatic drive(input int h, input int v, input bit hs, input bit hb, input bit vs,
                       input bit vb, input int rgb, input int exp_xy, input int exp_rgb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    hblnk_in  = hb;
    vsync_in  = vs;
    vblnk_in  = vb;
    rgb_in    = 12'(rgb);
    qx.push_back('{due: edge_cnt + 1, xy: 7'(exp_xy)});
    qp.push_back('{due: edge_cnt + 3, rgb: 12'(exp_rgb),
                   tim: {11'(h), hs, hb, 11'(v), vs, vb}});
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input int rgb, input int exp_xy, input int exp_rgb);
    drive(h, v, 1'(h), 1'b0, 1'(v >> 2), 1'b0, rgb, exp_xy, exp_rgb);
  endtask

  initial begin
    for (int i = 0; i < 100; i++) mem[i] = 2'b00;
    mem[23] = 2'b01;
    mem[24] = 2'b10;
    mem[33] = 2'b11;

    // Reset held for two edges with active inputs
    rst = 1'b1;
    hcount_in = 11'd165; vcount_in = 11'd133; rgb_in = 12'hFFF;
    hsync_in = 1'b1; hblnk_in = 1'b0; vsync_in = 1'b1; vblnk_in = 1'b0;
    for (int i = 1; i <= 2; i++) qx.push_back('{due: i, xy: 7'd0});
    for (int i = 1; i <= 4; i++) qp.push_back('{due: i, rgb: 12'h000, tim: 26'd0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    //   h    v    rgb_in   xy   rgb_out
    pix( 64,  64, 12'h111,   0, 12'h000);   // board corner is grid
    pix(165, 133, 12'h222,  23, 12'h888);   // ship
    pix(200, 133, 12'h333,  24, 12'hF00);   // hit
    pix(170, 180, 12'h444,  33, 12'hFFF);   // miss
    pix(100, 100, 12'h555,  11, 12'h05A);   // water
    pix(383, 383, 12'h666,  99, 12'h000);   // last column/row is grid
    pix(384, 383, 12'h123,   0, 12'h123);   // just right of board
    pix( 63, 100, 12'h777,   0, 12'h777);   // just left of board
    pix(200, 384, 12'h321,   0, 12'h321);   // just below board
    pix(200, 383, 12'h888,  94, 12'h000);   // bottom grid row
    pix( 95,  70, 12'h999,   0, 12'h05A);   // cell 0 interior
    pix( 10,  10, 12'hABC,   0, 12'hABC);   // far outside
    drive(165, 133, 1'b0, 1'b1, 1'b0, 1'b0, 12'h456, 23, 12'h000);  // hblnk on board
    drive(100, 100, 1'b1, 1'b0, 1'b1, 1'b1, 12'h457, 11, 12'h000);  // vblnk on board
    drive( 20,  20, 1'b1, 1'b1, 1'b0, 1'b1, 12'h458,  0, 12'h000);  // blank off board
`ifdef CURSOR_HIGHLIGHT_EN
    pix(160, 140, 12'h100,  23, 12'hFF0);   // cursor cell outline
`else
    pix(160, 140, 12'h100,  23, 12'h000);
`endif
    pix(165, 140, 12'h101,  23, 12'h888);   // cursor cell interior keeps its code
    pix(192, 140, 12'h102,  24, 12'h000);   // neighbour outline stays grid

    // Miniature frame with blanking and sync pulses
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 20; h++) begin
        automatic bit hb  = (h >= 16);
        automatic bit vb  = (v == 3);
        automatic bit hs  = (h == 17 || h == 18);
        automatic bit vs  = (v == 3 && h < 10);
        automatic int rgb = (h * 256 + v * 16 + 5) & 12'hFFF;
        drive(h, v, hs, hb, vs, vb, rgb, 0, (hb || vb) ? 0 : rgb);
      end
    end

    for (int i = 0; i < 20 && (qx.size() > 0 || qp.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (qx.size() > 0 || qp.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", qx.size() + qp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
